// File: rtl/datapath_multi.sv
// Instruction executor over three latency-configurable synchronous RAMs (general, NN, framebuffer).
// Handles single-access opcodes plus multi-cycle framebuffer CLEAR and pipelined REFRESH scan-out.

module datapath_multi_ram #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_addr;

  // NOTE: storage arrays get no reset so they map onto block RAM; state uses <= so all flops update together.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_addr <= i_addr;
  end

  if (LAT == 1) begin : g_direct
    assign o_q = r_mem[r_addr];
  end else begin : g_pipe
    logic [DW-1:0] r_q [LAT-1];
    always_ff @(posedge clock) begin
      r_q[0] <= r_mem[r_addr];
      for (int i = 1; i < LAT - 1; i++) r_q[i] <= r_q[i-1];
    end
    assign o_q = r_q[LAT-2];
  end
endmodule

module datapath_multi #(
  parameter int INSTR_W     = 32,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int MEM_ADDR_W  = 8,
  parameter int MEM_DATA_W  = 16,
  parameter int NN_ADDR_W   = 10,
  parameter int NN_DATA_W   = 6,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic [NN_DATA_W-1:0]  nnmem_data,
  output logic [MEM_DATA_W-1:0] result,
  output logic [NN_DATA_W-1:0]  nnmem_output,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot,
  output logic                  finished,
  output logic                  error
);
  localparam int N_PIX = SCREEN_W * SCREEN_H;
  localparam int FB_AW = $clog2(N_PIX);
  localparam int WC_W  = $clog2(MEM_LATENCY + 1);

  localparam logic [3:0] OP_NOP = 4'd0, OP_DRAW = 4'd1, OP_MEMREAD = 4'd2, OP_MEMWRITE = 4'd3,
                         OP_DISPLAY = 4'd4, OP_NNMEMREAD = 4'd5, OP_NNMEMWRITE = 4'd6,
                         OP_CLEAR = 4'd7, OP_REFRESH = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_SCAN, S_DRAIN} state_e;
  state_e r_state, w_next;

  logic [INSTR_W-1:0]    r_instr;
  logic                  r_finished, r_error, r_plot;
  logic [MEM_DATA_W-1:0] r_result;
  logic [FB_AW-1:0]      r_cnt;
  logic [X_W-1:0]        r_sx, r_x;
  logic [Y_W-1:0]        r_sy, r_y;
  logic [COLOUR_W-1:0]   r_colour;
  logic [WC_W-1:0]       r_wcnt;
  logic [X_W-1:0]        r_xp [MEM_LATENCY];
  logic [Y_W-1:0]        r_yp [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] r_vld;

  logic [3:0]            w_op;
  logic [X_W-1:0]        w_px;
  logic [Y_W-1:0]        w_py;
  logic [COLOUR_W-1:0]   w_pc;
  logic                  w_we, w_oor, w_illegal, w_accept, w_done;
  logic                  w_wait_end, w_drain_end, w_clear_end, w_last_pix;
  logic [MEM_ADDR_W-1:0] w_maddr;
  logic [MEM_DATA_W-1:0] w_mdata, w_mem_q;
  logic [NN_ADDR_W-1:0]  w_naddr;
  logic [NN_DATA_W-1:0]  w_nn_q;
  logic [FB_AW-1:0]      w_fb_pix, w_scan_addr, w_fb_addr;
  logic [COLOUR_W-1:0]   w_fb_q;
  logic                  w_mem_we, w_nn_we, w_fb_we;

  assign w_op      = r_instr[3:0];
  assign w_px      = r_instr[4 +: X_W];
  assign w_py      = r_instr[4 + X_W +: Y_W];
  assign w_pc      = r_instr[4 + X_W + Y_W +: COLOUR_W];
  assign w_we      = r_instr[4 + X_W + Y_W + COLOUR_W];
  assign w_maddr   = r_instr[4 +: MEM_ADDR_W];
  assign w_mdata   = r_instr[INSTR_W-1 -: MEM_DATA_W];
  assign w_naddr   = r_instr[4 +: NN_ADDR_W];

  assign w_oor       = (int'(w_px) >= SCREEN_W) || (int'(w_py) >= SCREEN_H);
  assign w_illegal   = (w_op > OP_REFRESH);
  assign w_fb_pix    = FB_AW'(int'(w_py) * SCREEN_W + int'(w_px));
  assign w_scan_addr = FB_AW'(int'(r_sy) * SCREEN_W + int'(r_sx));
  assign w_wait_end  = (r_wcnt == WC_W'(MEM_LATENCY - 1));
  assign w_drain_end = (r_wcnt == WC_W'(MEM_LATENCY));
  assign w_clear_end = (r_cnt == FB_AW'(N_PIX - 1));
  assign w_last_pix  = (r_sx == X_W'(SCREEN_W - 1)) && (r_sy == Y_W'(SCREEN_H - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && r_finished) w_next = S_ISSUE;
      S_ISSUE: begin
        case (w_op)
          OP_DRAW, OP_MEMREAD, OP_MEMWRITE, OP_DISPLAY,
          OP_NNMEMREAD, OP_NNMEMWRITE: w_next = S_WAIT;
          OP_CLEAR:                    w_next = S_CLEAR;
          OP_REFRESH:                  w_next = S_SCAN;
          default:                     w_next = S_IDLE;
        endcase
      end
      S_WAIT:  if (w_wait_end)  w_next = S_IDLE;
      S_CLEAR: if (w_clear_end) w_next = S_IDLE;
      S_SCAN:  if (w_last_pix)  w_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && start && r_finished;
  assign w_done   = (r_state != S_IDLE) && (w_next == S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr    <= '0;
      r_finished <= 1'b1;
      r_error    <= 1'b0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_wcnt     <= '0;
    end else begin
      if (w_accept) begin
        r_instr    <= instruction;
        r_finished <= 1'b0;
        r_error    <= 1'b0;
      end
      if (w_done) r_finished <= 1'b1;
      case (r_state)
        S_ISSUE: begin
          r_error <= w_illegal || (w_oor && (w_op == OP_DRAW || w_op == OP_DISPLAY));
          r_cnt   <= '0;
          r_sx    <= '0;
          r_sy    <= '0;
          r_wcnt  <= '0;
        end
        S_WAIT, S_DRAIN: r_wcnt <= r_wcnt + WC_W'(1);
        S_CLEAR: if (!w_clear_end) r_cnt <= r_cnt + FB_AW'(1);
        S_SCAN: begin
          r_wcnt <= '0;
          if (r_sx == X_W'(SCREEN_W - 1)) begin
            r_sx <= '0;
            r_sy <= (r_sy == Y_W'(SCREEN_H - 1)) ? '0 : r_sy + Y_W'(1);
          end else begin
            r_sx <= r_sx + X_W'(1);
          end
        end
        default: ;
      endcase
      if (r_state == S_WAIT && w_wait_end) begin
        if (w_op == OP_MEMREAD)        r_result <= w_mem_q;
        else if (w_op == OP_NNMEMREAD) r_result <= MEM_DATA_W'(w_nn_q);
      end
    end
  end

  // Scan coordinates travel alongside the framebuffer read so they meet its q.
  always_ff @(posedge clock) begin
    r_xp[0] <= r_sx;
    r_yp[0] <= r_sy;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      r_xp[i] <= r_xp[i-1];
      r_yp[i] <= r_yp[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= (r_state == S_SCAN);
      for (int i = 1; i < MEM_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      r_plot <= 1'b0;
      if (r_vld[MEM_LATENCY-1]) begin
        r_plot   <= 1'b1;
        r_x      <= r_xp[MEM_LATENCY-1];
        r_y      <= r_yp[MEM_LATENCY-1];
        r_colour <= w_fb_q;
      end else if (r_state == S_WAIT && w_wait_end && w_op == OP_DISPLAY && !w_oor) begin
        r_plot   <= 1'b1;
        r_x      <= w_px;
        r_y      <= w_py;
        r_colour <= w_fb_q;
      end
    end
  end

  assign w_mem_we = (r_state == S_ISSUE) && (w_op == OP_MEMWRITE);
  assign w_nn_we  = (r_state == S_ISSUE) && (w_op == OP_NNMEMWRITE);
  assign w_fb_we  = ((r_state == S_ISSUE) && (w_op == OP_DRAW) && w_we && !w_oor) ||
                    (r_state == S_CLEAR);

  always_comb begin
    w_fb_addr = w_fb_pix;
    if (r_state == S_CLEAR)     w_fb_addr = r_cnt;
    else if (r_state == S_SCAN) w_fb_addr = w_scan_addr;
  end

  datapath_multi_ram #(.DW(MEM_DATA_W), .AW(MEM_ADDR_W), .DEPTH(1 << MEM_ADDR_W), .LAT(MEM_LATENCY)) u_mem (
    .clock(clock), .i_we(w_mem_we), .i_addr(w_maddr), .i_wdata(w_mdata), .o_q(w_mem_q));

  datapath_multi_ram #(.DW(NN_DATA_W), .AW(NN_ADDR_W), .DEPTH(1 << NN_ADDR_W), .LAT(MEM_LATENCY)) u_nn (
    .clock(clock), .i_we(w_nn_we), .i_addr(w_naddr), .i_wdata(nnmem_data), .o_q(w_nn_q));

  datapath_multi_ram #(.DW(COLOUR_W), .AW(FB_AW), .DEPTH(N_PIX), .LAT(MEM_LATENCY)) u_fb (
    .clock(clock), .i_we(w_fb_we), .i_addr(w_fb_addr), .i_wdata(w_pc), .o_q(w_fb_q));

  assign result       = r_result;
  assign nnmem_output = w_nn_q;
  assign x            = r_x;
  assign y            = r_y;
  assign colour       = r_colour;
  assign plot         = r_plot;
  assign finished     = r_finished;
  assign error        = r_error;
endmodule
